// File: rtl/fc_pkg.sv
// Shared types for the fully-connected data mover.
// FSM encodings and the lane slice helper.
package fc_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_WRITE,
    S_DONE
  } state_t;

  function automatic int lane_lo(
    input int lane,
    input int width
  );
    return lane * width;
  endfunction

endpackage

// File: rtl/fc_mac_lane.sv
// One signed multiply-accumulate lane.
// The accumulator wraps modulo 2^ACC_WIDTH.
module fc_mac_lane #(
  parameter int IN_DATA_WIDTH = 8,
  parameter int ACC_WIDTH     = 32
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     valid_i,
  input  logic                     clr_i,
  input  logic [IN_DATA_WIDTH-1:0] a_i,
  input  logic [IN_DATA_WIDTH-1:0] b_i,
  output logic [ACC_WIDTH-1:0]     acc_o
);

  localparam int XW = ACC_WIDTH - IN_DATA_WIDTH;

  logic [ACC_WIDTH-1:0] a_x;
  logic [ACC_WIDTH-1:0] b_x;
  logic [ACC_WIDTH-1:0] prod;

  // Low ACC_WIDTH bits of the widened product equal the signed product.
  assign a_x  = {{XW{a_i[IN_DATA_WIDTH-1]}}, a_i};
  assign b_x  = {{XW{b_i[IN_DATA_WIDTH-1]}}, b_i};
  assign prod = a_x * b_x;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_o <= '0;
    end else if (clr_i) begin
      acc_o <= '0;
    end else if (valid_i) begin
      acc_o <= acc_o + prod;
    end
  end

endmodule

// File: rtl/fc_data_mover_multi.sv
// Multi-node FC engine: streams inputs and weight rows,
// runs LANES MAC lanes, writes one reduced sum per node.
module fc_data_mover_multi
  import fc_pkg::*;
#(
  parameter int LANES         = 4,
  parameter int IN_DATA_WIDTH = 8,
  parameter int DWIDTH        = LANES * IN_DATA_WIDTH,
  parameter int ACC_WIDTH     = 32,
  parameter int AWIDTH        = 12,
  parameter int CNT_BIT       = 16,
  parameter int RD_LATENCY    = 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start_run_i,
  input  logic [CNT_BIT-1:0]   run_count_i,
  input  logic [CNT_BIT-1:0]   node_count_i,
  output logic                 idle_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [CNT_BIT-1:0]   node_idx_o,
  output logic [AWIDTH-1:0]    addr_b0_o,
  output logic                 ce_b0_o,
  output logic                 we_b0_o,
  output logic [DWIDTH-1:0]    d_b0_o,
  input  logic [DWIDTH-1:0]    q_b0_i,
  output logic [AWIDTH-1:0]    addr_b1_o,
  output logic                 ce_b1_o,
  output logic                 we_b1_o,
  output logic [DWIDTH-1:0]    d_b1_o,
  input  logic [DWIDTH-1:0]    q_b1_i,
  output logic [AWIDTH-1:0]    addr_b2_o,
  output logic                 ce_b2_o,
  output logic                 we_b2_o,
  output logic [ACC_WIDTH-1:0] d_b2_o
);

  localparam int DCW = $clog2(RD_LATENCY + 2);

  state_t               state;
  state_t               nstate;
  logic [CNT_BIT-1:0]   k_q;
  logic [CNT_BIT-1:0]   n_q;
  logic [CNT_BIT-1:0]   kc_q;
  logic [CNT_BIT-1:0]   nc_q;
  logic [AWIDTH-1:0]    base_q;
  logic [DCW-1:0]       dcnt_q;
  logic [RD_LATENCY-1:0] vld_q;
  logic                 rd_valid;
  logic                 k_last;
  logic                 n_last;
  logic                 d_last;
  logic                 go;
  logic [ACC_WIDTH-1:0] acc [LANES];
  logic [ACC_WIDTH-1:0] sum;

  assign go     = (run_count_i != '0) && (node_count_i != '0);
  assign k_last = (k_q == kc_q - CNT_BIT'(1));
  assign n_last = (n_q == nc_q - CNT_BIT'(1));
  assign d_last = (dcnt_q == DCW'(RD_LATENCY));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= nstate;
    end
  end

  always_comb begin
    nstate = state;
    unique case (state)
      S_IDLE: begin
        if (start_run_i) begin
          nstate = go ? S_RUN : S_DONE;
        end
      end
      S_RUN: begin
        if (k_last) begin
          nstate = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (d_last) begin
          nstate = S_WRITE;
        end
      end
      S_WRITE: begin
        nstate = n_last ? S_DONE : S_RUN;
      end
      S_DONE: begin
        nstate = S_IDLE;
      end
      default: begin
        nstate = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      k_q    <= '0;
      n_q    <= '0;
      kc_q   <= '0;
      nc_q   <= '0;
      base_q <= '0;
      dcnt_q <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start_run_i) begin
            kc_q   <= run_count_i;
            nc_q   <= node_count_i;
            k_q    <= '0;
            n_q    <= '0;
            base_q <= '0;
            dcnt_q <= '0;
          end
        end
        S_RUN: begin
          k_q <= k_last ? '0 : k_q + CNT_BIT'(1);
        end
        S_DRAIN: begin
          dcnt_q <= d_last ? '0 : dcnt_q + DCW'(1);
        end
        S_WRITE: begin
          if (!n_last) begin
            n_q    <= n_q + CNT_BIT'(1);
            base_q <= base_q + AWIDTH'(kc_q);
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Read-data qualifier: RUN delayed by the BRAM read latency.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_q <= '0;
    end else begin
      vld_q[0] <= (state == S_RUN);
      for (int i = 1; i < RD_LATENCY; i++) begin
        vld_q[i] <= vld_q[i-1];
      end
    end
  end

  assign rd_valid = vld_q[RD_LATENCY-1];

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    localparam int LO = lane_lo(i, IN_DATA_WIDTH);
    fc_mac_lane #(
      .IN_DATA_WIDTH(IN_DATA_WIDTH),
      .ACC_WIDTH    (ACC_WIDTH)
    ) u_lane (
      .clk    (clk),
      .reset_n(reset_n),
      .valid_i(rd_valid),
      .clr_i  (state == S_WRITE),
      .a_i    (q_b0_i[LO +: IN_DATA_WIDTH]),
      .b_i    (q_b1_i[LO +: IN_DATA_WIDTH]),
      .acc_o  (acc[i])
    );
  end

  always_comb begin
    sum = '0;
    for (int i = 0; i < LANES; i++) begin
      sum = sum + acc[i];
    end
  end

  always_comb begin
    idle_o    = (state == S_IDLE);
    busy_o    = 1'b0;
    done_o    = (state == S_DONE);
    ce_b0_o   = 1'b0;
    ce_b1_o   = 1'b0;
    addr_b0_o = '0;
    addr_b1_o = '0;
    ce_b2_o   = 1'b0;
    we_b2_o   = 1'b0;
    addr_b2_o = '0;
    d_b2_o    = '0;
    unique case (state)
      S_RUN: begin
        busy_o    = 1'b1;
        ce_b0_o   = 1'b1;
        ce_b1_o   = 1'b1;
        addr_b0_o = AWIDTH'(k_q);
        addr_b1_o = base_q + AWIDTH'(k_q);
      end
      S_DRAIN: begin
        busy_o = 1'b1;
      end
      S_WRITE: begin
        busy_o    = 1'b1;
        ce_b2_o   = 1'b1;
        we_b2_o   = 1'b1;
        addr_b2_o = AWIDTH'(n_q);
        d_b2_o    = sum;
      end
      default: begin
      end
    endcase
  end

  assign node_idx_o = n_q;
  assign we_b0_o    = 1'b0;
  assign d_b0_o     = '0;
  assign we_b1_o    = 1'b0;
  assign d_b1_o     = '0;

endmodule

// File: tb/tb_fc_data_mover_multi.sv
// Scoreboard bench: two DUTs (read latency 1 and 3)
// driven in lockstep, each with its own BRAM model.
module tb_fc_data_mover_multi;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] kk = '0;
  logic [15:0] nn = '0;

  always #5 clk = ~clk;

  logic [31:0] mem0 [4096];
  logic [31:0] mem1 [4096];

  logic        idle_0, busy_0, done_0, idle_1, busy_1, done_1;
  logic [15:0] nidx_0, nidx_1;
  logic [11:0] a0_0, a1_0, a2_0, a0_1, a1_1, a2_1;
  logic        ce0_0, ce1_0, ce2_0, we0_0, we1_0, we2_0;
  logic        ce0_1, ce1_1, ce2_1, we0_1, we1_1, we2_1;
  logic [31:0] d0_0, d1_0, d2_0, d0_1, d1_1, d2_1;
  logic [31:0] q0_0, q1_0, q0_1, q1_1;
  logic [31:0] p0_0, p1_0;
  logic [31:0] p0_1 [3];
  logic [31:0] p1_1 [3];

  fc_data_mover_multi #(.RD_LATENCY(1)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .start_run_i(start),
    .run_count_i(kk), .node_count_i(nn),
    .idle_o(idle_0), .busy_o(busy_0), .done_o(done_0),
    .node_idx_o(nidx_0),
    .addr_b0_o(a0_0), .ce_b0_o(ce0_0), .we_b0_o(we0_0),
    .d_b0_o(d0_0), .q_b0_i(q0_0),
    .addr_b1_o(a1_0), .ce_b1_o(ce1_0), .we_b1_o(we1_0),
    .d_b1_o(d1_0), .q_b1_i(q1_0),
    .addr_b2_o(a2_0), .ce_b2_o(ce2_0), .we_b2_o(we2_0),
    .d_b2_o(d2_0)
  );

  fc_data_mover_multi #(.RD_LATENCY(3)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .start_run_i(start),
    .run_count_i(kk), .node_count_i(nn),
    .idle_o(idle_1), .busy_o(busy_1), .done_o(done_1),
    .node_idx_o(nidx_1),
    .addr_b0_o(a0_1), .ce_b0_o(ce0_1), .we_b0_o(we0_1),
    .d_b0_o(d0_1), .q_b0_i(q0_1),
    .addr_b1_o(a1_1), .ce_b1_o(ce1_1), .we_b1_o(we1_1),
    .d_b1_o(d1_1), .q_b1_i(q1_1),
    .addr_b2_o(a2_1), .ce_b2_o(ce2_1), .we_b2_o(we2_1),
    .d_b2_o(d2_1)
  );

  always @(posedge clk) begin
    p0_0    <= mem0[a0_0];
    p1_0    <= mem1[a1_0];
    p0_1[0] <= mem0[a0_1];
    p0_1[1] <= p0_1[0];
    p0_1[2] <= p0_1[1];
    p1_1[0] <= mem1[a1_1];
    p1_1[1] <= p1_1[0];
    p1_1[2] <= p1_1[1];
  end

  assign q0_0 = p0_0;
  assign q1_0 = p1_0;
  assign q0_1 = p0_1[2];
  assign q1_1 = p1_1[2];

  int errors = 0;
  int checks = 0;
  logic [23:0] rq0 [$];
  logic [23:0] rq1 [$];
  logic [43:0] wq0 [$];
  logic [43:0] wq1 [$];

  task automatic chk(input string name, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, got, exp);
    end
  endtask

  task automatic monitor();
    logic [23:0] er;
    logic [43:0] ew;
    forever begin
      @(negedge clk);
      if (ce0_0 || ce1_0) begin
        if (rq0.size() == 0) begin
          chk("rd0 unexpected", {ce0_0, ce1_0, a0_0, a1_0}, 0);
        end else begin
          er = rq0.pop_front();
          chk("rd0 addr", {ce0_0, ce1_0, a0_0, a1_0}, {2'b11, er});
        end
      end
      if (ce0_1 || ce1_1) begin
        if (rq1.size() == 0) begin
          chk("rd1 unexpected", {ce0_1, ce1_1, a0_1, a1_1}, 0);
        end else begin
          er = rq1.pop_front();
          chk("rd1 addr", {ce0_1, ce1_1, a0_1, a1_1}, {2'b11, er});
        end
      end
      if (ce2_0 || we2_0) begin
        if (wq0.size() == 0) begin
          chk("wr0 unexpected", {ce2_0, we2_0, a2_0, d2_0}, 0);
        end else begin
          ew = wq0.pop_front();
          chk("wr0 data", {ce2_0, we2_0, a2_0, d2_0}, {2'b11, ew});
        end
      end
      if (ce2_1 || we2_1) begin
        if (wq1.size() == 0) begin
          chk("wr1 unexpected", {ce2_1, we2_1, a2_1, d2_1}, 0);
        end else begin
          ew = wq1.pop_front();
          chk("wr1 data", {ce2_1, we2_1, a2_1, d2_1}, {2'b11, ew});
        end
      end
    end
  endtask

  function automatic logic [31:0] model(input int n, input int k_n);
    int s;
    logic signed [7:0] a;
    logic signed [7:0] b;
    logic [31:0] wa;
    logic [31:0] wb;
    s = 0;
    for (int k = 0; k < k_n; k++) begin
      wa = mem0[k];
      wb = mem1[(n * k_n + k) % 4096];
      for (int i = 0; i < 4; i++) begin
        a = wa[i*8 +: 8];
        b = wb[i*8 +: 8];
        s = s + int'(a) * int'(b);
      end
    end
    return s;
  endfunction

  task automatic run(input int k_n, input int n_n, input int restart,
                     input int abort, input bit hand,
                     input logic [31:0] hv);
    int c, d0, d1, ni0, ni1, e0, e1, nlim;
    bit s0, s1;
    logic [43:0] w;
    nlim = (abort != 0) ? 1 : n_n;
    if (k_n != 0) begin
      for (int n = 0; n < nlim; n++) begin
        for (int k = 0; k < k_n; k++) begin
          rq0.push_back({12'(k), 12'(n * k_n + k)});
          rq1.push_back({12'(k), 12'(n * k_n + k)});
        end
        if (abort == 0) begin
          w = {12'(n), (hand && n == 0) ? hv : model(n, k_n)};
          wq0.push_back(w);
          wq1.push_back(w);
        end
      end
    end
    kk = 16'(k_n);
    nn = 16'(n_n);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    c = 1; s0 = 0; s1 = 0; ni0 = 0; ni1 = 0; d0 = 0; d1 = 0;
    while (!(s0 && s1) && c < 300) begin
      if (abort != 0 && c == abort) break;
      start = (c == restart);
      if (!idle_0 && !s0) ni0++;
      if (!idle_1 && !s1) ni1++;
      if (done_0 && !s0) begin s0 = 1; d0 = c; end
      if (done_1 && !s1) begin s1 = 1; d1 = c; end
      @(posedge clk);
      #1;
      c++;
    end
    start = 1'b0;
    if (abort != 0) begin
      reset_n = 1'b0;
      #1;
      chk("abort idle/busy", {idle_0, busy_0, idle_1, busy_1}, 4'b1010);
      repeat (2) @(posedge clk);
      #1;
      reset_n = 1'b1;
      chk("abort reads left", 64'(rq0.size() + rq1.size()), 0);
      return;
    end
    e0 = (k_n == 0 || n_n == 0) ? 1 : n_n * (k_n + 3) + 1;
    e1 = (k_n == 0 || n_n == 0) ? 1 : n_n * (k_n + 5) + 1;
    chk("done0 cycle", 64'(d0), 64'(e0));
    chk("done1 cycle", 64'(d1), 64'(e1));
    chk("nonidle0 cycles", 64'(ni0), 64'(e0));
    chk("nonidle1 cycles", 64'(ni1), 64'(e1));
    repeat (2) @(posedge clk);
    #1;
    chk("queues drained",
        64'(rq0.size() + rq1.size() + wq0.size() + wq1.size()), 0);
  endtask

  task automatic load_t3();
    mem0[0] = 32'h7F80FF01;
    mem0[1] = 32'h12345678;
    mem0[2] = 32'hF00DCAFE;
    mem1[0] = 32'h01020304;
    mem1[1] = 32'hFF7F8001;
    mem1[2] = 32'h10203040;
    mem1[3] = 32'hFEFDFCFB;
    mem1[4] = 32'h80808080;
    mem1[5] = 32'h7F7F7F7F;
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) begin
      mem0[i] = '0;
      mem1[i] = '0;
    end
    fork
      monitor();
    join_none
    #2;
    chk("rst status0", {idle_0, busy_0, done_0, nidx_0}, {3'b100, 16'h0});
    chk("rst status1", {idle_1, busy_1, done_1, nidx_1}, {3'b100, 16'h0});
    chk("rst bram0", {ce0_0, ce1_0, ce2_0, we2_0, a2_0, d2_0}, 0);
    chk("rst bram1", {ce0_1, ce1_1, ce2_1, we2_1, a2_1, d2_1}, 0);
    chk("rst rd ports", {we0_0, we1_0, we0_1, we1_1}, 0);
    chk("rst rd data", {d0_0, d1_0}, 0);
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    mem0[0] = 32'h04030201;
    mem1[0] = 32'h01010101;
    run(1, 1, 0, 0, 1'b1, 32'd10);

    mem0[0] = 32'h000000FF;
    mem1[0] = 32'h00000002;
    run(1, 1, 0, 0, 1'b1, 32'hFFFFFFFE);

    load_t3();
    run(3, 2, 0, 0, 1'b0, 32'h0);

    run(0, 3, 0, 0, 1'b0, 32'h0);
    run(2, 0, 0, 0, 1'b0, 32'h0);

    run(3, 2, 2, 0, 1'b0, 32'h0);

    mem0[3] = 32'h80017F02;
    mem1[6] = 32'h03FF05FB;
    mem1[7] = 32'h11223344;
    run(4, 2, 0, 5, 1'b0, 32'h0);
    @(posedge clk);
    #1;
    chk("post-abort idle", {idle_0, idle_1, nidx_0, nidx_1}, {2'b11, 32'h0});
    run(4, 2, 0, 0, 1'b0, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
